// File: rtl/mpsoc_noc_vchannel_serializer.sv
// Merges per-VC packet streams onto one shared-flit router input channel.
// Round-robin arbitration at packet granularity; out_* are driven straight from flops.
module mpsoc_noc_vchannel_serializer #(
   parameter int FLIT_WIDTH = 32,
   parameter int VCHANNELS  = 7
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [VCHANNELS-1:0][FLIT_WIDTH-1:0] in_flit,
   input  logic [VCHANNELS-1:0]                 in_last,
   input  logic [VCHANNELS-1:0]                 in_valid,
   output logic [VCHANNELS-1:0]                 in_ready,
   output logic [FLIT_WIDTH-1:0]                out_flit,
   output logic                                 out_last,
   output logic [VCHANNELS-1:0]                 out_valid,
   input  logic [VCHANNELS-1:0]                 out_ready
);

   localparam int VC_W = (VCHANNELS > 1) ? $clog2(VCHANNELS) : 1;

   typedef logic [VC_W-1:0] vc_t;
   typedef enum logic {IDLE, LOCKED} state_e;

   state_e                 state_q;
   vc_t                    lock_vc_q;
   vc_t                    rr_ptr_q;
   logic [VCHANNELS-1:0]   out_valid_q;
   logic [FLIT_WIDTH-1:0]  out_flit_q;
   logic                   out_last_q;

   logic                   hi_found;
   logic                   lo_found;
   vc_t                    hi_vc;
   vc_t                    lo_vc;
   vc_t                    sel_vc;
   vc_t                    next_ptr;
   logic                   sel_en;
   logic [VCHANNELS-1:0]   sel_onehot;
   logic [FLIT_WIDTH-1:0]  sel_flit;
   logic                   sel_last;
   logic                   reg_full;
   logic                   drain;
   logic                   can_load;
   logic                   accept;

   // The output register is full exactly when one VC's valid bit is set.
   assign reg_full = |out_valid_q;
   assign drain    = |(out_valid_q & out_ready);
   assign can_load = ~reg_full | drain;

   // NOTE: every signal written in an always_comb gets a default first, so no latch is inferred.
   always_comb begin
      hi_found = 1'b0;
      lo_found = 1'b0;
      hi_vc    = '0;
      lo_vc    = '0;
      // Descending scan leaves the lowest matching index; hi covers rr_ptr..N-1, lo is the wrap case.
      for (int v = VCHANNELS - 1; v >= 0; v--) begin
         if (in_valid[v]) begin
            lo_found = 1'b1;
            lo_vc    = vc_t'(v);
            if (vc_t'(v) >= rr_ptr_q) begin
               hi_found = 1'b1;
               hi_vc    = vc_t'(v);
            end
         end
      end
   end

   always_comb begin
      sel_en     = (state_q == LOCKED) | lo_found;
      sel_vc     = (state_q == LOCKED) ? lock_vc_q : (hi_found ? hi_vc : lo_vc);
      next_ptr   = (sel_vc == vc_t'(VCHANNELS - 1)) ? '0 : sel_vc + vc_t'(1);
      sel_onehot = '0;
      sel_flit   = '0;
      sel_last   = 1'b0;
      for (int i = 0; i < VCHANNELS; i++) begin
         if (vc_t'(i) == sel_vc) begin
            sel_onehot[i] = 1'b1;
            sel_flit      = in_flit[i];
            sel_last      = in_last[i];
         end
      end
      in_ready = (!rst && sel_en && can_load) ? sel_onehot : '0;
      accept   = |(in_ready & in_valid);
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: the flit register is reset as well because the router must see out_flit=0 out of reset.
         state_q     <= IDLE;
         lock_vc_q   <= '0;
         rr_ptr_q    <= '0;
         out_valid_q <= '0;
         out_flit_q  <= '0;
         out_last_q  <= 1'b0;
      end else begin
         if (accept) begin
            out_valid_q <= sel_onehot;
            out_flit_q  <= sel_flit;
            out_last_q  <= sel_last;
         end else if (drain) begin
            out_valid_q <= '0;
         end

         // In LOCKED sel_vc is lock_vc, so one rule covers both states.
         if (accept) begin
            if (sel_last) begin
               state_q  <= IDLE;
               rr_ptr_q <= next_ptr;
            end else begin
               state_q   <= LOCKED;
               lock_vc_q <= sel_vc;
            end
         end
      end
   end

   assign out_valid = out_valid_q;
   assign out_flit  = out_flit_q;
   assign out_last  = out_last_q;

endmodule

// File: tb/tb_mpsoc_noc_vchannel_serializer.sv
// Directed bench for the VC serializer: 7-VC, 3-VC and 1-VC instances share clk and rst.
module tb_mpsoc_noc_vchannel_serializer;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   logic [6:0][31:0] in_flit7   = '0;
   logic [6:0]       in_last7   = '0;
   logic [6:0]       in_valid7  = '0;
   logic [6:0]       in_ready7;
   logic [31:0]      out_flit7;
   logic             out_last7;
   logic [6:0]       out_valid7;
   logic [6:0]       out_ready7 = '1;

   logic [2:0][31:0] in_flit3   = '0;
   logic [2:0]       in_last3   = '0;
   logic [2:0]       in_valid3  = '0;
   logic [2:0]       in_ready3;
   logic [31:0]      out_flit3;
   logic             out_last3;
   logic [2:0]       out_valid3;
   logic [2:0]       out_ready3 = '1;

   logic [0:0][31:0] in_flit1   = '0;
   logic [0:0]       in_last1   = '0;
   logic [0:0]       in_valid1  = '0;
   logic [0:0]       in_ready1;
   logic [31:0]      out_flit1;
   logic             out_last1;
   logic [0:0]       out_valid1;
   logic [0:0]       out_ready1 = '1;

   mpsoc_noc_vchannel_serializer #(.FLIT_WIDTH(32), .VCHANNELS(7)) u7 (
      .clk(clk), .rst(rst), .in_flit(in_flit7), .in_last(in_last7), .in_valid(in_valid7),
      .in_ready(in_ready7), .out_flit(out_flit7), .out_last(out_last7), .out_valid(out_valid7),
      .out_ready(out_ready7));

   mpsoc_noc_vchannel_serializer #(.FLIT_WIDTH(32), .VCHANNELS(3)) u3 (
      .clk(clk), .rst(rst), .in_flit(in_flit3), .in_last(in_last3), .in_valid(in_valid3),
      .in_ready(in_ready3), .out_flit(out_flit3), .out_last(out_last3), .out_valid(out_valid3),
      .out_ready(out_ready3));

   mpsoc_noc_vchannel_serializer #(.FLIT_WIDTH(32), .VCHANNELS(1)) u1 (
      .clk(clk), .rst(rst), .in_flit(in_flit1), .in_last(in_last1), .in_valid(in_valid1),
      .in_ready(in_ready1), .out_flit(out_flit1), .out_last(out_last1), .out_valid(out_valid1),
      .out_ready(out_ready1));

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // out_valid must never be multi-hot
   always @(negedge clk) begin
      check("onehot7", 64'($onehot0(out_valid7)), 64'd1);
      check("onehot3", 64'($onehot0(out_valid3)), 64'd1);
   end

   logic [15:0] pat_v = 16'b1011_0111_1101_1010;
   logic [15:0] pat_r = 16'b1101_1011_0110_1111;
   int   n_sent;
   int   n_recv;
   logic acc_in;
   logic acc_out;
   logic hold;

   initial begin
      // Reset: in_ready stays 0 even with requests pending
      in_valid7 = 7'h7F;
      tick();
      tick();
      check("rst out_valid", out_valid7, 7'h00);
      check("rst out_flit", out_flit7, 32'h0);
      check("rst out_last", out_last7, 1'b0);
      check("rst in_ready", in_ready7, 7'h00);
      rst = 1'b0;
      in_valid7 = '0;

      // 1: single-flit packet on VC2
      in_flit7[2] = 32'hA5A5A5A5;
      in_last7[2] = 1'b1;
      in_valid7   = 7'b0000100;
      #1 check("t1 in_ready", in_ready7, 7'h04);
      tick();
      in_valid7 = '0;
      check("t1 out_valid", out_valid7, 7'h04);
      check("t1 out_flit", out_flit7, 32'hA5A5A5A5);
      check("t1 out_last", out_last7, 1'b1);
      // rr_ptr=3: VC4 beats VC1, then ptr=5 gives VC1
      in_flit7[1] = 32'h41; in_last7[1] = 1'b1;
      in_flit7[4] = 32'h44; in_last7[4] = 1'b1;
      in_valid7   = 7'b0010010;
      #1 check("t1 rr grant4", in_ready7, 7'h10);
      tick();
      check("t1 out vc4", out_flit7, 32'h44);
      check("t1 valid vc4", out_valid7, 7'h10);
      in_valid7 = 7'b0000010;
      #1 check("t1 rr grant1", in_ready7, 7'h02);
      tick();
      check("t1 out vc1", out_flit7, 32'h41);
      check("t1 valid vc1", out_valid7, 7'h02);
      in_valid7 = '0;

      // 2: VC0 4-flit packet while VC1 stays valid (rr_ptr=2 -> VC0 first)
      in_flit7[1] = 32'h20;
      in_last7[1] = 1'b1;
      for (int k = 0; k < 4; k++) begin
         in_flit7[0] = 32'h10 + 32'(k);
         in_last7[0] = (k == 3);
         in_valid7   = 7'b0000011;
         #1 check("t2 in_ready", in_ready7, 7'h01);
         tick();
         check("t2 out_flit", out_flit7, 64'h10 + 64'(k));
         check("t2 out_valid", out_valid7, 7'h01);
         check("t2 out_last", out_last7, (k == 3) ? 1'b1 : 1'b0);
      end
      in_valid7 = 7'b0000010;
      #1 check("t2 vc1 ready", in_ready7, 7'h02);
      tick();
      check("t2 vc1 flit", out_flit7, 32'h20);
      check("t2 vc1 valid", out_valid7, 7'h02);
      in_valid7 = '0;
      tick();
      check("t2 drained", out_valid7, 7'h00);

      // 4: VC3 stalled by out_ready[3]=0 (rr_ptr=2 -> VC3)
      in_flit7[3] = 32'h33; in_last7[3] = 1'b1;
      out_ready7  = 7'b1110111;
      in_valid7   = 7'b0001000;
      #1 check("t4 in_ready", in_ready7, 7'h08);
      tick();
      in_flit7[3] = 32'h34;
      in_flit7[5] = 32'h55; in_last7[5] = 1'b1;
      in_valid7   = 7'b0101000;
      for (int k = 0; k < 5; k++) begin
         #1 check("t4 stall ready", in_ready7, 7'h00);
         check("t4 stall flit", out_flit7, 32'h33);
         check("t4 stall valid", out_valid7, 7'h08);
         tick();
      end
      out_ready7 = '1;
      #1 check("t4 release ready", in_ready7, 7'h20);
      tick();
      check("t4 replace flit", out_flit7, 32'h55);
      check("t4 replace valid", out_valid7, 7'h20);
      in_valid7 = 7'b0001000;
      #1 check("t4 vc3 ready", in_ready7, 7'h08);
      tick();
      check("t4 vc3 flit", out_flit7, 32'h34);
      in_valid7 = '0;
      tick();

      // 5: lock VC5 (rr_ptr=4), bubble, then async reset mid-packet
      in_flit7[5] = 32'h50; in_last7[5] = 1'b0;
      in_valid7   = 7'b0100000;
      #1 check("t5 ready vc5", in_ready7, 7'h20);
      tick();
      check("t5 flit 50", out_flit7, 32'h50);
      in_flit7[2] = 32'h22; in_last7[2] = 1'b1;
      in_valid7   = 7'b0000100;
      #1 check("t5 bubble ready", in_ready7, 7'h20);
      tick();
      check("t5 bubble empty", out_valid7, 7'h00);
      in_flit7[5] = 32'h51;
      in_valid7   = 7'b0100000;
      tick();
      check("t5 flit 51", out_flit7, 32'h51);
      check("t5 last 51", out_last7, 1'b0);
      in_flit7[5] = 32'h52;
      in_flit7[1] = 32'h11; in_last7[1] = 1'b1;
      in_valid7   = 7'b0100010;
      #1 check("t5 lock holds", in_ready7, 7'h20);
      rst = 1'b1;
      #1 check("t5 rst valid", out_valid7, 7'h00);
      check("t5 rst flit", out_flit7, 32'h0);
      check("t5 rst ready", in_ready7, 7'h00);
      tick();
      rst = 1'b0;
      #1 check("t5 post rst grant", in_ready7, 7'h02);
      tick();
      check("t5 post rst flit", out_flit7, 32'h11);
      check("t5 post rst valid", out_valid7, 7'h02);
      check("t5 post rst last", out_last7, 1'b1);
      in_valid7 = '0;
      tick();

      // 3: VCHANNELS=3, all VCs continuously offering single-flit packets
      for (int v = 0; v < 3; v++) in_flit3[v] = 32'h100 + 32'(v);
      in_last3  = '1;
      in_valid3 = '1;
      for (int k = 0; k < 6; k++) begin
         #1 check("t3 in_ready", in_ready3, 64'(1) << (k % 3));
         tick();
         check("t3 out_flit", out_flit3, 64'h100 + 64'(k % 3));
         check("t3 out_valid", out_valid3, 64'(1) << (k % 3));
      end
      in_valid3 = '0;

      // 6: VCHANNELS=1, four 3-flit packets with valid/ready gaps
      n_sent = 0;
      n_recv = 0;
      hold   = 1'b0;
      for (int cyc = 0; cyc < 200 && n_recv < 12; cyc++) begin
         in_valid1   = (n_sent < 12) && (hold || pat_v[cyc % 16]);
         in_flit1[0] = 32'h600 + 32'(n_sent);
         in_last1    = (n_sent % 3 == 2);
         out_ready1  = pat_r[cyc % 16];
         #1;
         acc_in  = in_valid1[0] & in_ready1[0];
         acc_out = out_valid1[0] & out_ready1[0];
         hold    = in_valid1[0] & ~acc_in;
         if (acc_out) begin
            check("t6 flit", out_flit1, 64'h600 + 64'(n_recv));
            check("t6 last", out_last1, (n_recv % 3 == 2) ? 1'b1 : 1'b0);
            n_recv++;
         end
         tick();
         if (acc_in) n_sent++;
      end
      check("t6 received", 64'(n_recv), 64'd12);
      in_valid1  = '0;
      out_ready1 = '1;
      tick();
      check("t6 no dup", out_valid1, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
